// File: rtl/alu_pkg.sv
// Encodings shared by the execute-stage ALU and the multiply/divide sequencer:
// ALU control codes, the MULTU/DIVU op select and the sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer: one shift-add or restoring-subtract step
// per cycle on the shared external ALU, committing the result into HI/LO.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] alu_res,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctr
);
  import alu_pkg::*;

  localparam logic [4:0] CNT_LAST = 5'd31;

  md_state_t        state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] m_reg, m_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [4:0]       cnt_reg, cnt_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH-1:0] step_acc, step_q;
  logic [WIDTH-1:0] div_r;
  logic             div_rmsb;
  logic             mul_carry;
  logic             div_take;

  // Divide: shifted partial remainder is 33 bits wide; its top bit is kept apart
  // so the 32-bit ALU subtract still yields the right wrapped remainder.
  assign div_r     = {acc_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign div_rmsb  = acc_reg[WIDTH-1];
  assign div_take  = div_rmsb || (div_r >= m_reg);
  assign mul_carry = (alu_res < acc_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      cnt_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      m_reg     <= m_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      cnt_reg   <= cnt_next;
      dbz_reg   <= dbz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    q_next     = q_reg;
    m_next     = m_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    cnt_next   = cnt_reg;
    dbz_next   = dbz_reg;
    step_acc   = acc_reg;
    step_q     = q_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (hi_we) hi_next = wdata;
        if (lo_we) lo_next = wdata;
        if (start) begin
          cnt_next = '0;
          dbz_next = 1'b0;
          acc_next = '0;
          if (op == OP_MULTU) begin
            q_next     = rt_val;
            m_next     = rs_val;
            state_next = ST_MUL;
          end else if (rt_val == '0) begin
            // Zero divisor resolves immediately without touching the ALU.
            hi_next    = rs_val;
            lo_next    = '1;
            dbz_next   = 1'b1;
            state_next = ST_DONE;
          end else begin
            q_next     = rs_val;
            m_next     = rt_val;
            state_next = ST_DIV;
          end
        end
      end

      ST_MUL: begin
        if (q_reg[0]) begin
          step_acc = {mul_carry, alu_res[WIDTH-1:1]};
          step_q   = {alu_res[0], q_reg[WIDTH-1:1]};
        end else begin
          step_acc = {1'b0, acc_reg[WIDTH-1:1]};
          step_q   = {acc_reg[0], q_reg[WIDTH-1:1]};
        end
        acc_next = step_acc;
        q_next   = step_q;
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == CNT_LAST) begin
          hi_next    = step_acc;
          lo_next    = step_q;
          state_next = ST_DONE;
        end
      end

      ST_DIV: begin
        if (div_take) begin
          step_acc = alu_res;
          step_q   = {q_reg[WIDTH-2:0], 1'b1};
        end else begin
          step_acc = div_r;
          step_q   = {q_reg[WIDTH-2:0], 1'b0};
        end
        acc_next = step_acc;
        q_next   = step_q;
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == CNT_LAST) begin
          hi_next    = step_acc;
          lo_next    = step_q;
          state_next = ST_DONE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state only; nothing flows from inputs.
  always_comb begin
    busy    = 1'b0;
    alu_own = 1'b0;
    done    = 1'b0;
    alu_ctr = ALU_NOP;
    alu_in1 = '0;
    alu_in2 = '0;
    case (state_reg)
      ST_MUL: begin
        busy    = 1'b1;
        alu_own = 1'b1;
        alu_ctr = ALU_ADD;
        alu_in1 = acc_reg;
        alu_in2 = m_reg;
      end
      ST_DIV: begin
        busy    = 1'b1;
        alu_own = 1'b1;
        alu_ctr = ALU_SUB;
        alu_in1 = div_r;
        alu_in2 = m_reg;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign hi          = hi_reg;
  assign lo          = lo_reg;
  assign div_by_zero = dbz_reg;

endmodule
